// File: rtl/timer.sv
// timer: bus-mapped DIV/TIMA/TMA/TAC timer with TIMA overflow reload and one-clock irq
// Ports: clk, reset (sync, active-high); t_cycle/mem_addr/mem_enable/mem_write/mem_data_in bus inputs;
// mem_data_out (0xFF when unselected), mem_selected, irq_timer.
// Optional: define TIMER_TAC_GLITCH_EN to let a TAC write that drops the tick signal increment TIMA.
module timer #(
  parameter logic [15:0] BASE_ADDR = 16'hFF04
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  t_cycle,
  input  logic [15:0] mem_addr,
  input  logic        mem_enable,
  input  logic        mem_write,
  input  logic [7:0]  mem_data_in,
  output logic [7:0]  mem_data_out,
  output logic        mem_selected,
  output logic        irq_timer
);
  logic [15:0] sys_counter;
  logic [7:0]  tima, tma;
  logic [2:0]  tac;
  logic [1:0]  delay;
  logic        reload_pending, edge_prev;
  logic        wr, wr_div, wr_tima, wr_tma, wr_tac;
  logic        tick_old, tick_new, tick_sig, prev_next, inc, reload;
  function automatic logic tick_of(input logic [15:0] c, input logic [2:0] t);
    return t[2] & (t[1] ? (t[0] ? c[7] : c[5]) : (t[0] ? c[3] : c[9]));
  endfunction
  assign mem_selected = mem_enable && mem_addr[15:2] == BASE_ADDR[15:2];
  assign wr      = mem_selected && mem_write && t_cycle == 2'd3;
  assign wr_div  = wr && mem_addr[1:0] == 2'd0;
  assign wr_tima = wr && mem_addr[1:0] == 2'd1;
  assign wr_tma  = wr && mem_addr[1:0] == 2'd2;
  assign wr_tac  = wr && mem_addr[1:0] == 2'd3;
  assign tick_old = tick_of(sys_counter, tac);
  assign tick_new = tick_of(sys_counter, mem_data_in[2:0]);
`ifdef TIMER_TAC_GLITCH_EN
  assign tick_sig  = wr_tac ? tick_new : tick_old;
  assign prev_next = tick_sig;
`else
  assign tick_sig  = tick_old;
  assign prev_next = wr_tac ? tick_new : tick_old;
`endif
  assign inc    = edge_prev & ~tick_sig;
  assign reload = reload_pending && delay == 2'd0;
  always_comb
    mem_data_out = !mem_selected ? 8'hFF :
                   mem_addr[1:0] == 2'd0 ? sys_counter[15:8] :
                   mem_addr[1:0] == 2'd1 ? tima :
                   mem_addr[1:0] == 2'd2 ? tma : {5'b11111, tac};
  always_ff @(posedge clk) begin
    if (reset) begin
      sys_counter    <= '0;
      tima           <= '0;
      tma            <= '0;
      tac            <= '0;
      delay          <= '0;
      reload_pending <= 1'b0;
      edge_prev      <= 1'b0;
      irq_timer      <= 1'b0;
    end else begin
      sys_counter <= wr_div ? 16'd0 : sys_counter + 16'd1;
      edge_prev   <= prev_next;
      irq_timer   <= reload && !wr_tima;
      tma         <= wr_tma ? mem_data_in : tma;
      tac         <= wr_tac ? mem_data_in[2:0] : tac;
      if (wr_tima) begin
        tima           <= mem_data_in;
        reload_pending <= 1'b0;
      end else if (reload) begin
        tima           <= wr_tma ? mem_data_in : tma;
        reload_pending <= 1'b0;
      end else if (reload_pending) begin
        delay <= delay - 2'd1;
      end else if (inc) begin
        tima           <= tima + 8'd1;
        reload_pending <= &tima;
        delay          <= 2'd3;
      end
    end
  end
endmodule

// File: tb/tb_timer.sv
// tb_timer: randomized and directed checks of timer against a cycle-level reference model
module tb_timer;
  localparam logic [15:0] BASE = 16'hFF04;
  logic        clk = 0, reset = 1;
  logic [1:0]  t_cycle = 0;
  logic [15:0] mem_addr = 0;
  logic        mem_enable = 0, mem_write = 0;
  logic [7:0]  mem_data_in = 0;
  logic [7:0]  mem_data_out;
  logic        mem_selected, irq_timer;
  int n_chk = 0, n_pass = 0;
  logic [15:0] m_cnt;
  logic [7:0]  m_tima, m_tma;
  logic [2:0]  m_tac;
  logic        m_prev, m_irq;
  int          m_cd;
  timer #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .t_cycle(t_cycle), .mem_addr(mem_addr),
    .mem_enable(mem_enable), .mem_write(mem_write), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_selected(mem_selected), .irq_timer(irq_timer)
  );
  always #5 clk = ~clk;
  function automatic bit src(input logic [15:0] c, input logic [2:0] t);
    int idx;
    idx = t[1:0] == 0 ? 9 : t[1:0] == 1 ? 3 : t[1:0] == 2 ? 5 : 7;
    return t[2] && ((c >> idx) & 16'd1) != 0;
  endfunction
  function automatic bit in_range(input logic [15:0] a);
    return int'(a) >= int'(BASE) && int'(a) <= int'(BASE) + 3;
  endfunction
  function automatic logic [7:0] m_read(input logic en, input logic [15:0] a);
    if (!(en && in_range(a))) return 8'hFF;
    case (int'(a) - int'(BASE))
      0: return m_cnt[15:8];
      1: return m_tima;
      2: return m_tma;
      default: return {5'b11111, m_tac};
    endcase
  endfunction
  task automatic model_step();
    bit w, cur, nprev, fall;
    int o;
    logic [2:0] ntac;
    if (reset) begin
      m_cnt = 0; m_tima = 0; m_tma = 0; m_tac = 0; m_prev = 0; m_irq = 0; m_cd = -1;
      return;
    end
    w = mem_enable && mem_write && t_cycle == 3 && in_range(mem_addr);
    o = int'(mem_addr) - int'(BASE);
    ntac = (w && o == 3) ? mem_data_in[2:0] : m_tac;
`ifdef TIMER_TAC_GLITCH_EN
    cur = src(m_cnt, ntac);
    nprev = cur;
`else
    cur = src(m_cnt, m_tac);
    nprev = src(m_cnt, ntac);
`endif
    fall = m_prev && !cur;
    m_irq = 0;
    if (m_cd == 0) begin
      m_tima = (w && o == 2) ? mem_data_in : m_tma;
      m_irq = 1;
      m_cd = -1;
    end else if (m_cd > 0) m_cd--;
    else if (fall) begin
      if (m_tima == 8'hFF) begin m_tima = 0; m_cd = 3; end
      else m_tima++;
    end
    if (w && o == 1) begin m_tima = mem_data_in; m_cd = -1; m_irq = 0; end
    if (w && o == 2) m_tma = mem_data_in;
    m_tac = ntac;
    m_prev = nprev;
    m_cnt = (w && o == 0) ? 16'd0 : m_cnt + 16'd1;
  endtask
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask
  task automatic idle();
    mem_enable = 0; mem_write = 0; t_cycle = 0;
  endtask
  task automatic wr(input int off, input logic [7:0] d);
    mem_enable = 1; mem_write = 1; t_cycle = 3;
    mem_addr = BASE + 16'(off); mem_data_in = d;
    cyc();
    idle();
  endtask
  task automatic rd(input int off, output logic [7:0] d);
    mem_enable = 1; mem_write = 0; t_cycle = 0; mem_addr = BASE + 16'(off);
    #1 d = mem_data_out;
  endtask
  task automatic do_reset();
    reset = 1; idle();
    cyc(); cyc();
    reset = 0;
  endtask
  task automatic test_reset();
    logic [7:0] d;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rd(i, d);
      n_chk++;
      if (d !== (i == 3 ? 8'hF8 : 8'h00)) $display("FAIL reset_reg%0d got %h want %h", i, d, i == 3 ? 8'hF8 : 8'h00);
      else n_pass++;
    end
    n_chk++;
    if (irq_timer !== 1'b0) $display("FAIL reset_irq got %b want 0", irq_timer); else n_pass++;
    mem_addr = 16'hFF00; #1;
    n_chk++;
    if (mem_data_out !== 8'hFF || mem_selected !== 1'b0)
      $display("FAIL unselected got %h/%b want ff/0", mem_data_out, mem_selected);
    else n_pass++;
    idle();
  endtask
  task automatic test_div();
    logic [7:0] d;
    do_reset();
    for (int i = 0; i < 256; i++) cyc();
    rd(0, d);
    n_chk++;
    if (d !== 8'h01) $display("FAIL div_256 got %h want 01", d); else n_pass++;
    idle();
    for (int i = 256; i < 65536; i++) cyc();
    rd(0, d);
    n_chk++;
    if (d !== 8'h00 || d !== m_cnt[15:8]) $display("FAIL div_wrap got %h want 00", d); else n_pass++;
    idle();
  endtask
  task automatic test_count();
    logic [7:0] d;
    do_reset();
    wr(3, 8'h05);
    wr(1, 8'h00);
    for (int i = 0; i < 16; i++) cyc();
    rd(1, d);
    n_chk++;
    if (d !== 8'h01 || d !== m_tima) $display("FAIL tima_16 got %h want 01 (model %h)", d, m_tima); else n_pass++;
    idle();
    for (int i = 16; i < 160; i++) cyc();
    rd(1, d);
    n_chk++;
    if (d !== 8'h0A || d !== m_tima) $display("FAIL tima_160 got %h want 0a (model %h)", d, m_tima); else n_pass++;
    idle();
  endtask
  task automatic setup_overflow();
    do_reset();
    wr(2, 8'hAB);
    wr(3, 8'h05);
    wr(1, 8'hFF);
    for (int i = 0; i < 40 && m_cd != 3; i++) cyc();
    n_chk++;
    if (m_cd != 3) $display("FAIL overflow_timeout got cd=%0d want 3", m_cd); else n_pass++;
  endtask
  task automatic test_overflow();
    logic [7:0] d;
    setup_overflow();
    for (int i = 0; i < 4; i++) begin
      rd(1, d);
      n_chk++;
      if (d !== 8'h00 || irq_timer !== 1'b0) $display("FAIL ovf_zero%0d got %h/%b want 00/0", i, d, irq_timer);
      else n_pass++;
      idle();
      cyc();
    end
    rd(1, d);
    n_chk++;
    if (d !== 8'hAB || irq_timer !== 1'b1) $display("FAIL ovf_reload got %h/%b want ab/1", d, irq_timer);
    else n_pass++;
    idle();
    cyc();
    n_chk++;
    if (irq_timer !== 1'b0) $display("FAIL irq_width got %b want 0", irq_timer); else n_pass++;
  endtask
  task automatic test_cancel();
    logic [7:0] d;
    int irqs = 0;
    setup_overflow();
    cyc();
    wr(1, 8'h42);
    for (int i = 0; i < 6; i++) begin
      irqs += int'(irq_timer);
      cyc();
    end
    rd(1, d);
    n_chk++;
    if (d !== 8'h42 || irqs != 0) $display("FAIL cancel got %h irqs=%0d want 42 irqs=0", d, irqs); else n_pass++;
    idle();
  endtask
  task automatic test_div_edge();
    logic [7:0] d;
    do_reset();
    wr(3, 8'h05);
    wr(1, 8'h10);
    for (int i = 0; i < 40 && m_cnt[3:0] != 4'h9; i++) cyc();
    wr(0, 8'h77);
    cyc(); cyc();
    rd(1, d);
    n_chk++;
    if (d !== 8'h11) $display("FAIL div_edge_tima got %h want 11", d); else n_pass++;
    rd(0, d);
    n_chk++;
    if (d !== 8'h00) $display("FAIL div_edge_div got %h want 00", d); else n_pass++;
    idle();
  endtask
  task automatic test_tac_glitch();
    logic [7:0] d;
    logic [7:0] want;
    do_reset();
    wr(3, 8'h05);
    wr(1, 8'h20);
    for (int i = 0; i < 40 && m_cnt[3:0] != 4'h9; i++) cyc();
    wr(3, 8'h00);
    cyc(); cyc(); cyc();
`ifdef TIMER_TAC_GLITCH_EN
    want = 8'h21;
`else
    want = 8'h20;
`endif
    rd(1, d);
    n_chk++;
    if (d !== want) $display("FAIL tac_glitch got %h want %h", d, want); else n_pass++;
    rd(3, d);
    n_chk++;
    if (d !== 8'hF8) $display("FAIL tac_read got %h want f8", d); else n_pass++;
    idle();
  endtask
  task automatic test_random();
    int bad = 0;
    logic [7:0] exp_d;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      mem_enable = ($urandom_range(0, 3) != 0);
      mem_write = ($urandom_range(0, 3) == 0);
      t_cycle = 2'($urandom_range(0, 3));
      mem_addr = BASE + 16'($urandom_range(0, 5)) - 16'd1;
      mem_data_in = 8'($urandom);
      if (mem_addr == BASE + 16'd3 && $urandom_range(0, 3) != 0) mem_data_in[2] = 1'b1;
      if (mem_addr == BASE && $urandom_range(0, 3) != 0) mem_write = 0;
      #1;
      exp_d = m_read(mem_enable, mem_addr);
      n_chk++;
      if (mem_data_out !== exp_d || mem_selected !== (mem_enable && in_range(mem_addr)) || irq_timer !== m_irq) begin
        if (bad < 10) $display("FAIL random@%0d got %h/%b/%b want %h/%b/%b", i, mem_data_out, mem_selected,
                               irq_timer, exp_d, mem_enable && in_range(mem_addr), m_irq);
        bad++;
      end else n_pass++;
      cyc();
    end
    reset = 0;
    idle();
  endtask
  initial begin
    test_reset();
    test_div();
    test_count();
    test_overflow();
    test_cancel();
    test_div_edge();
    test_tac_glitch();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
